// File: rtl/keypad_pkg.sv
// Shared types and the key layout for the hex keypad entry path.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CAND = 2'd1,
        HELD = 2'd2
    } kp_state_e;

    typedef enum logic [1:0] {
        EMPTY  = 2'd0,
        SINGLE = 2'd1,
        MULTI  = 2'd2
    } frame_class_e;

    // Physical layout: row0 1 2 3 A, row1 4 5 6 B, row2 7 8 9 C, row3 0 F E D.
    function automatic logic [3:0] keymap(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = 4'hA;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = 4'hB;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = 4'hC;
            4'd12:   code = 4'h0;
            4'd13:   code = 4'hF;
            4'd14:   code = 4'hE;
            default: code = 4'hD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_row_scanner.sv
// Drives one keypad row at a time, samples the synchronized columns at the end
// of each row dwell and classifies the completed 4-row snapshot.
module keypad_row_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [3:0]   i_col,
    output logic [3:0]   o_row,
    output logic         o_frame_done,
    output frame_class_e o_class,
    output logic [3:0]   o_code
);
    localparam int              DW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    r_sync1;
    logic [3:0]    r_sync2;
    logic [3:0]    r_row;
    logic [1:0]    r_row_idx;
    logic [DW-1:0] r_dwell;
    logic [11:0]   r_snap;

    logic          w_sample;
    logic [15:0]   w_pressed;
    logic [4:0]    w_n_down;
    logic [3:0]    w_hit_idx;

    assign w_sample     = (r_dwell == DWELL_LAST);
    assign o_row        = r_row;
    assign o_frame_done = w_sample && (r_row_idx == 2'd3);
    // Row 3 is classified straight from the synchronizer on its sample cycle.
    assign w_pressed    = {~r_sync2, r_snap};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 4'hF;
            r_sync2   <= 4'hF;
            r_row     <= 4'b1110;
            r_row_idx <= 2'd0;
            r_dwell   <= '0;
            r_snap    <= '0;
        end else begin
            r_sync1 <= i_col;
            r_sync2 <= r_sync1;
            if (w_sample) begin
                r_dwell   <= '0;
                r_row_idx <= r_row_idx + 2'd1;
                r_row     <= {r_row[2:0], r_row[3]};
                case (r_row_idx)
                    2'd0:    r_snap[3:0]  <= ~r_sync2;
                    2'd1:    r_snap[7:4]  <= ~r_sync2;
                    2'd2:    r_snap[11:8] <= ~r_sync2;
                    default: ;
                endcase
            end else begin
                r_dwell <= r_dwell + DW'(1);
            end
        end
    end

    always_comb begin
        w_n_down  = '0;
        w_hit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (w_pressed[i]) begin
                w_n_down  = w_n_down + 5'd1;
                w_hit_idx = 4'(i);
            end
        end
    end

    always_comb begin
        if (w_n_down == 5'd0) begin
            o_class = EMPTY;
        end else if (w_n_down == 5'd1) begin
            o_class = SINGLE;
        end else begin
            o_class = MULTI;
        end
    end

    assign o_code = keymap(w_hit_idx[3:2], w_hit_idx[1:0]);

endmodule

// File: rtl/hex_keypad_entry.sv
// Hex keypad front end: per-frame debounce of single key presses and an
// 8-nibble shift register of accepted keys, newest key in bits [3:0].
//
//   state | meaning
//   IDLE  | waiting for a frame with exactly one key down
//   CAND  | same single key seen r_cnt consecutive frames
//   HELD  | key accepted; r_cnt counts consecutive empty frames to release
module hex_keypad_entry
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int DEBOUNCE = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [3:0]  o_row,
    input  logic [3:0]  i_col,
    input  logic        i_clr,
    output logic [31:0] o_nibbles,
    output logic        o_key_valid,
    output logic [3:0]  o_key_code,
    output logic [3:0]  o_entry_count
);
    localparam logic [3:0] DB_LAST = 4'(DEBOUNCE);

    kp_state_e    r_state;
    logic [3:0]   r_cand;
    logic [3:0]   r_cnt;

    logic         w_frame_done;
    frame_class_e w_class;
    logic [3:0]   w_code;
    logic         w_same;
    logic         w_accept;

    keypad_row_scanner #(
        .SCAN_DIV(SCAN_DIV)
    ) u_scanner (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_col       (i_col),
        .o_row       (o_row),
        .o_frame_done(w_frame_done),
        .o_class     (w_class),
        .o_code      (w_code)
    );

    assign w_same = (w_class == SINGLE) && (w_code == r_cand);

    always_comb begin
        w_accept = 1'b0;
        if (w_frame_done) begin
            case (r_state)
                IDLE:    w_accept = (w_class == SINGLE) && (DB_LAST == 4'd1);
                CAND:    w_accept = w_same && ((r_cnt + 4'd1) == DB_LAST);
                default: w_accept = 1'b0;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_cand  <= 4'h0;
            r_cnt   <= 4'd0;
        end else if (w_frame_done) begin
            case (r_state)
                IDLE: begin
                    if (w_class == SINGLE) begin
                        r_cand <= w_code;
                        if (w_accept) begin
                            r_state <= HELD;
                            r_cnt   <= 4'd0;
                        end else begin
                            r_state <= CAND;
                            r_cnt   <= 4'd1;
                        end
                    end
                end
                CAND: begin
                    if (w_accept) begin
                        r_state <= HELD;
                        r_cnt   <= 4'd0;
                    end else if (w_same) begin
                        r_cnt <= r_cnt + 4'd1;
                    end else if (w_class == SINGLE) begin
                        r_cand <= w_code;
                        r_cnt  <= 4'd1;
                    end else begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end
                end
                HELD: begin
                    if (w_class != EMPTY) begin
                        r_cnt <= 4'd0;
                    end else if ((r_cnt + 4'd1) == DB_LAST) begin
                        r_state <= IDLE;
                        r_cnt   <= 4'd0;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    // Clear takes priority over the shift, but the accept pulse and code still go out.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_nibbles     <= '0;
            o_key_valid   <= 1'b0;
            o_key_code    <= 4'h0;
            o_entry_count <= 4'd0;
        end else begin
            o_key_valid <= w_accept;
            if (w_accept) begin
                o_key_code <= w_code;
            end
            if (i_clr) begin
                o_nibbles     <= '0;
                o_entry_count <= 4'd0;
            end else if (w_accept) begin
                o_nibbles <= {o_nibbles[27:0], w_code};
                if (o_entry_count < 4'd8) begin
                    o_entry_count <= o_entry_count + 4'd1;
                end
            end
        end
    end

endmodule
